// File: rtl/gearbox_rx_sync.sv
// PMA-width to 66-bit RX gearbox with an integrated block-lock state machine.
// When unlocked, it slips the block alignment by one bit at a time until the sync headers line up.
module gearbox_rx_sync #(
  parameter int PMA_W  = 64,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int GOOD_N = 64,
  parameter int BAD_N  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_v_i,
  input  logic [PMA_W-1:0]  data_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o,
  output logic              lock_o,
  output logic              slip_o
);

  localparam int BLOCK_W = HEAD_W + DATA_W;
  localparam int BUF_W   = BLOCK_W + PMA_W - 1;
  localparam int CNT_W   = $clog2(BUF_W + 1);
  localparam int SH_W    = $clog2(GOOD_N + 1);
  localparam int BAD_W   = $clog2(BAD_N + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t             state;
  logic [BUF_W-1:0]   buf_q, buf_a, buf_s;
  logic [CNT_W-1:0]   cnt_q, cnt_a, cnt_s;
  logic [SH_W-1:0]    sh_cnt;
  logic [BAD_W-1:0]   bad_cnt;
  logic               slip_req, slip_go, emit, hdr_good;

  // data_v_i qualifies data_i for one cycle; there is no backpressure, so every valid word is consumed.
  // Bits above cnt_q are always zero, so appending is a plain OR of the shifted word.
  always_comb begin
    buf_a = buf_q;
    cnt_a = cnt_q;
    if (data_v_i) begin
      buf_a = buf_q | ({{(BUF_W-PMA_W){1'b0}}, data_i} << cnt_q);
      cnt_a = cnt_q + CNT_W'(PMA_W);
    end
    slip_go = slip_req && (cnt_a != '0);
    buf_s   = slip_go ? (buf_a >> 1) : buf_a;
    cnt_s   = cnt_a - CNT_W'(slip_go);
    emit    = cnt_s >= CNT_W'(BLOCK_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      head_o  <= '0;
      data_o  <= '0;
      slip_o  <= 1'b0;
    end else begin
      valid_o <= emit;
      slip_o  <= slip_go;
      if (emit) begin
        head_o <= buf_s[HEAD_W-1:0];
        data_o <= buf_s[BLOCK_W-1:HEAD_W];
        buf_q  <= buf_s >> BLOCK_W;
        cnt_q  <= cnt_s - CNT_W'(BLOCK_W);
      end else begin
        buf_q  <= buf_s;
        cnt_q  <= cnt_s;
      end
    end
  end

  assign hdr_good = (head_o == HEAD_W'(1)) || (head_o == HEAD_W'(2));

  // The lock FSM judges the registered block one cycle after valid_o.
  // Stale blocks are ignored while a slip is still pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= UNLOCKED;
      lock_o   <= 1'b0;
      sh_cnt   <= '0;
      bad_cnt  <= '0;
      slip_req <= 1'b0;
    end else begin
      if (slip_go) slip_req <= 1'b0;
      if (valid_o) begin
        case (state)
          UNLOCKED: begin
            if (!slip_req) begin
              if (hdr_good) begin
                if (sh_cnt == SH_W'(GOOD_N - 1)) begin
                  state   <= LOCKED;
                  lock_o  <= 1'b1;
                  sh_cnt  <= '0;
                  bad_cnt <= '0;
                end else begin
                  sh_cnt <= sh_cnt + 1'b1;
                end
              end else begin
                slip_req <= 1'b1;
                sh_cnt   <= '0;
              end
            end
          end
          LOCKED: begin
            if (!hdr_good && bad_cnt == BAD_W'(BAD_N - 1)) begin
              state    <= UNLOCKED;
              lock_o   <= 1'b0;
              slip_req <= 1'b1;
              sh_cnt   <= '0;
              bad_cnt  <= '0;
            end else if (sh_cnt == SH_W'(GOOD_N - 1)) begin
              sh_cnt  <= '0;
              bad_cnt <= '0;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
              if (!hdr_good) bad_cnt <= bad_cnt + 1'b1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gearbox_rx_sync.sv
// Bench for gearbox_rx_sync: three lanes (64/32/16-bit PMA) read one shared wire bitstream.
// A bit-pointer model predicts the outputs on every cycle.
module tb_gearbox_rx_sync;
  localparam int MAXB = 20480;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data_v = 1'b0;
  logic [2:0][63:0] din;
  logic [2:0]       vo, lo, so;
  logic [2:0][1:0]  ho;
  logic [2:0][63:0] dd;

  always #5 clk = ~clk;

  gearbox_rx_sync #(.PMA_W(64)) dut64 (.clk(clk), .reset(reset), .data_v_i(data_v), .data_i(din[0]),
    .valid_o(vo[0]), .head_o(ho[0]), .data_o(dd[0]), .lock_o(lo[0]), .slip_o(so[0]));
  gearbox_rx_sync #(.PMA_W(32)) dut32 (.clk(clk), .reset(reset), .data_v_i(data_v), .data_i(din[1][31:0]),
    .valid_o(vo[1]), .head_o(ho[1]), .data_o(dd[1]), .lock_o(lo[1]), .slip_o(so[1]));
  gearbox_rx_sync #(.PMA_W(16)) dut16 (.clk(clk), .reset(reset), .data_v_i(data_v), .data_i(din[2][15:0]),
    .valid_o(vo[2]), .head_o(ho[2]), .data_o(dd[2]), .lock_o(lo[2]), .slip_o(so[2]));

  logic sbit [0:MAXB-1];
  int lw [3] = '{64, 32, 16};

  // model: bits written / oldest unread bit index into the stream, plus lock bookkeeping
  int wr [3], rd [3], sh [3], bad [3];
  bit pend [3], m_lock [3], m_valid [3], m_slip [3];
  logic [65:0] m_blk [3];

  // observed events from the DUT outputs, per phase
  int rise [3], fall [3], sfall [3], fs [3], first_v [3], slips [3], vcnt33 [3];
  bit prev_lo [3];
  int passed, total, cyc;

  task automatic chk(input string name, input int l, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s lane%0d cyc %0d: got %h want %h", name, l, cyc, act, exp);
  endtask

  task automatic gen(input int off, input int b1lo, input int b1hi, input int b2lo, input int b2hi);
    int p;
    logic [65:0] blk;
    p = 0;
    for (int i = 0; i < off; i++) begin sbit[p] = 1'b1; p++; end
    for (int b = 0; p + 66 <= MAXB; b++) begin
      blk[65:2]  = {$urandom, $urandom};
      blk[65:61] = 5'h1f;  // makes every misaligned header 2'b11
      blk[1:0]   = ((b >= b1lo && b <= b1hi) || (b >= b2lo && b <= b2hi)) ? 2'b00 : 2'b01;
      for (int i = 0; i < 66; i++) begin sbit[p] = blk[i]; p++; end
    end
    while (p < MAXB) begin sbit[p] = 1'b0; p++; end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int l = 0; l < 3; l++) begin
      wr[l] = 0; rd[l] = 0; sh[l] = 0; bad[l] = 0;
      pend[l] = 0; m_lock[l] = 0; m_valid[l] = 0; m_slip[l] = 0; m_blk[l] = '0;
      rise[l] = -1; fall[l] = -1; sfall[l] = -1; fs[l] = -1; first_v[l] = -1;
      slips[l] = 0; vcnt33[l] = 0; prev_lo[l] = 0;
    end
  endtask

  task automatic model_step(input bit v);
    bit op, set, good, sgo;
    for (int l = 0; l < 3; l++) begin
      op = pend[l];
      set = 0;
      if (m_valid[l]) begin
        good = (m_blk[l][1:0] == 2'b01) || (m_blk[l][1:0] == 2'b10);
        if (!m_lock[l]) begin
          if (!op) begin
            if (good) begin
              sh[l]++;
              if (sh[l] == 64) begin m_lock[l] = 1; sh[l] = 0; bad[l] = 0; end
            end else begin
              set = 1; sh[l] = 0;
            end
          end
        end else begin
          sh[l]++;
          if (!good) bad[l]++;
          if (bad[l] == 16) begin m_lock[l] = 0; set = 1; sh[l] = 0; bad[l] = 0; end
          else if (sh[l] == 64) begin sh[l] = 0; bad[l] = 0; end
        end
      end
      if (v) wr[l] += lw[l];
      sgo = op && (wr[l] - rd[l] >= 1);
      if (sgo) rd[l]++;
      m_slip[l] = sgo;
      pend[l] = (op && !sgo) || set;
      if (wr[l] - rd[l] >= 66) begin
        for (int i = 0; i < 66; i++) m_blk[l][i] = sbit[rd[l] + i];
        rd[l] += 66;
        m_valid[l] = 1;
      end else begin
        m_valid[l] = 0;
      end
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic cycle(input bit v);
    data_v = v;
    for (int l = 0; l < 3; l++) begin
      din[l] = '0;
      if (v) for (int i = 0; i < lw[l]; i++) din[l][i] = sbit[wr[l] + i];
    end
    model_step(v);
    @(posedge clk);
    #1;
    cyc++;
    for (int l = 0; l < 3; l++) begin
      chk("valid", l, vo[l], m_valid[l]);
      chk("lock", l, lo[l], m_lock[l]);
      chk("slip", l, so[l], m_slip[l]);
      if (m_valid[l]) begin
        chk("head", l, ho[l], m_blk[l][1:0]);
        chk("data", l, dd[l], m_blk[l][65:2]);
      end
      if (lo[l] && rise[l] < 0) rise[l] = cyc;
      if (!lo[l] && prev_lo[l] && fall[l] < 0) fall[l] = cyc;
      if (so[l] && fs[l] < 0) fs[l] = cyc;
      if (so[l] && fall[l] >= 0 && sfall[l] < 0) sfall[l] = cyc;
      if (so[l]) slips[l]++;
      if (vo[l] && first_v[l] < 0) first_v[l] = cyc;
      if (vo[l] && cyc <= 33) vcnt33[l]++;
      prev_lo[l] = lo[l];
    end
    @(negedge clk);
  endtask

  // called at a negedge; reset is raised between edges to exercise the asynchronous path
  task automatic do_reset();
    data_v = 0;
    reset = 1;
    #1;
    for (int l = 0; l < 3; l++) begin
      chk("rst_valid", l, vo[l], 0);
      chk("rst_lock", l, lo[l], 0);
      chk("rst_slip", l, so[l], 0);
      chk("rst_head", l, ho[l], 0);
      chk("rst_data", l, dd[l], 0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  initial begin
    int exp_d [3];
    int exp_r [3];
    exp_d = '{32, 16, 8};
    exp_r = '{67, 133, 265};
    passed = 0;
    total = 0;
    din = '0;
    @(negedge clk);

    // aligned stream: rates and lock timing per width
    gen(0, -1, -1, -1, -1);
    do_reset();
    repeat (300) cycle(1'b1);
    for (int l = 0; l < 3; l++) begin
      chk("density33", l, vcnt33[l], exp_d[l]);
      chk("lock_rise", l, rise[l], exp_r[l]);
      chk("lock_end", l, lo[l], 1);
    end

    // reset while locked and mid-block, then a stream offset by 5 bits with idle gaps
    gen(5, -1, -1, -1, -1);
    do_reset();
    for (int k = 0; k < 200; k++) cycle(!(k >= 10 && k % 7 == 0));
    chk("first_valid", 0, first_v[0], 2);
    chk("first_valid", 2, first_v[2], 5);
    chk("first_slip", 0, fs[0], 4);
    chk("slip_count", 0, slips[0], 5);
    chk("offset_lock", 0, lo[0], 1);

    // 15 bad headers in one locked window hold lock; 16 in the next drop it
    gen(0, 64, 78, 128, 143);
    do_reset();
    repeat (200) cycle(1'b1);
    chk("lock_rise", 0, rise[0], 67);
    chk("lock_fall", 0, fall[0], 150);
    chk("slip_after_fall", 0, sfall[0], 151);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
